// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates a programmable number of 8-bit signed partial sums from the
//   8-lane dot-product PE into one output neuron value. A bias is added on the
//   first beat of each frame. The total is clamped to [-127, +127] and one
//   valid pulse is emitted per frame.
//
//   Optional build macro: PSUM_RELU_EN. When it is defined, a ReLU follows the
//   saturation stage, so negative results are output as 0x00. o_sat still
//   reports clamping that happens before the ReLU.
//
// Ports
//   clk      : clock
//   rst      : asynchronous, active-high reset
//   i_len    : partial sums per frame (0 is treated as 1); sampled on first beat
//   i_bias   : signed bias; sampled on first beat
//   i_psum   : signed partial sum from the dot PE
//   i_psum_v : partial sum valid; every valid beat is consumed
//   o_data   : signed saturated frame result; holds until the next completion
//   o_data_v : one-cycle pulse, one cycle after the last beat of a frame
//   o_busy   : high while a frame is in progress (state ACC)
//   o_sat    : sticky; set on any output clamp since reset
module psum_accumulator #(
    parameter int CNT_W = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] i_len,
    input  logic [7:0]       i_bias,
    input  logic [7:0]       i_psum,
    input  logic             i_psum_v,
    output logic [7:0]       o_data,
    output logic             o_data_v,
    output logic             o_busy,
    output logic             o_sat
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX;
    localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0]        CNT_ZERO = CNT_W'(32'd0);

    // Sign-extend an 8-bit value to the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext8(input logic [7:0] v);
        return {{(ACC_W-8){v[7]}}, v};
    endfunction

    // Symmetric clamp to [-127, +127]. Bit 8 of the result flags a clamp.
    function automatic logic [8:0] sat8(input logic signed [ACC_W-1:0] v);
        logic [8:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, 8'h7F};
        end else if (v < SAT_MIN) begin
            r = {1'b1, 8'h81};
        end else begin
            r = {1'b0, v[7:0]};
        end
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [7:0]              data_q, data_d;
    logic                    data_v_q, data_v_d;
    logic                    sat_q, sat_d;
    logic                    done_s;
    logic [8:0]              sat_res_s;
    logic [7:0]              out_val_s;

    // State register and all datapath / output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            data_q   <= 8'h00;
            data_v_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            data_q   <= data_d;
            data_v_q <= data_v_d;
            sat_q    <= sat_d;
        end
    end

    // Next-state and accumulation: the first beat of a frame seeds the
    // accumulator with bias + psum. Later beats add to it. done_s marks the
    // beat that completes the frame.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_psum_v) begin
                    len_d = (i_len == CNT_ZERO) ? CNT_ONE : i_len;
                    acc_d = sext8(i_bias) + sext8(i_psum);
                    cnt_d = CNT_ONE;
                    if (len_d == CNT_ONE) begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                if (i_psum_v) begin
                    acc_d = acc_q + sext8(i_psum);
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_d == len_q) begin
                        done_s  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = ACC;
                    end
                end else begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage: saturate the final accumulator value on the completing
    // beat, so the result is registered exactly one cycle after that beat.
    always_comb begin
        sat_res_s = sat8(acc_d);
`ifdef PSUM_RELU_EN
        if (sat_res_s[7]) begin
            out_val_s = 8'h00;
        end else begin
            out_val_s = sat_res_s[7:0];
        end
`else
        out_val_s = sat_res_s[7:0];
`endif
        data_v_d = done_s;
        if (done_s) begin
            data_d = out_val_s;
            sat_d  = sat_q | sat_res_s[8];
        end else begin
            data_d = data_q;
            sat_d  = sat_q;
        end
    end

    assign o_data   = data_q;
    assign o_data_v = data_v_q;
    assign o_busy   = (state_q == ACC);
    assign o_sat    = sat_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator. Each frame's expected result is pushed
// to a scoreboard queue when its last beat is driven. A monitor pops and checks
// the result, including exact one-cycle latency, on every o_data_v.
module tb_psum_accumulator;

    logic       clk;
    logic       rst;
    logic [7:0] i_len;
    logic [7:0] i_bias;
    logic [7:0] i_psum;
    logic       i_psum_v;
    logic [7:0] o_data;
    logic       o_data_v;
    logic       o_busy;
    logic       o_sat;

    int tests;
    int fails;
    int cyc;

    typedef struct {
        int         cycle;
        logic [7:0] data;
        logic       sat;
    } exp_t;

    exp_t sb_q[$];

    psum_accumulator #(.CNT_W(8), .ACC_W(18)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_len    (i_len),
        .i_bias   (i_bias),
        .i_psum   (i_psum),
        .i_psum_v (i_psum_v),
        .o_data   (o_data),
        .o_data_v (o_data_v),
        .o_busy   (o_busy),
        .o_sat    (o_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [7:0] len, input logic [7:0] bias, input logic [7:0] psum);
        @(negedge clk);
        i_psum_v = 1'b1;
        i_len    = len;
        i_bias   = bias;
        i_psum   = psum;
    endtask

    task automatic gap();
        @(negedge clk);
        i_psum_v = 1'b0;
        i_len    = 8'hAA;
        i_bias   = 8'h55;
        i_psum   = 8'h33;
    endtask

    // Called at the same negedge where the frame's last beat is driven.
    task automatic expect_frame(input logic [7:0] d, input logic s);
        exp_t e;
        e.cycle = cyc + 1;
        e.data  = d;
        e.sat   = s;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (!rst && o_data_v) begin
            chk("v_expected", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                chk("latency", cyc, e.cycle);
                chk("o_data", {24'd0, o_data}, {24'd0, e.data});
                chk("o_sat", {31'd0, o_sat}, {31'd0, e.sat});
            end
        end
    end

    initial begin
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        rst      = 1'b1;
        i_psum_v = 1'b0;
        i_len    = 8'h00;
        i_bias   = 8'h00;
        i_psum   = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_data", {24'd0, o_data}, 32'd0);
        chk("rst_v", {31'd0, o_data_v}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_sat", {31'd0, o_sat}, 32'd0);
        rst = 1'b0;
        gap();

        // Single-beat frame: 0x05 + 0x10 = 0x15, never busy.
        beat(8'd1, 8'h05, 8'h10);
        expect_frame(8'h15, 1'b0);
        gap();
        chk("len1_busy", {31'd0, o_busy}, 32'd0);
        chk("len1_v", {31'd0, o_data_v}, 32'd1);
        gap();
        chk("len1_pulse_end", {31'd0, o_data_v}, 32'd0);

        // len=4 with a 3-cycle gap after beat 2: 0x10+0x20-0x10+0x08 = 0x28.
        beat(8'd4, 8'h00, 8'h10);
        beat(8'd9, 8'h7F, 8'h20);
        chk("len4_busy_b1", {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            gap();
            chk("len4_busy_gap", {31'd0, o_busy}, 32'd1);
            chk("len4_no_v_gap", {31'd0, o_data_v}, 32'd0);
        end
        beat(8'd1, 8'h00, 8'hF0);
        chk("len4_busy_b3", {31'd0, o_busy}, 32'd1);
        beat(8'd1, 8'h00, 8'h08);
        expect_frame(8'h28, 1'b0);
        gap();
        chk("len4_idle_after", {31'd0, o_busy}, 32'd0);
        gap();

        // Positive clamp: 0x7F*4 = 508 -> 0x7F, sat set.
        beat(8'd3, 8'h7F, 8'h7F);
        beat(8'd3, 8'h00, 8'h7F);
        beat(8'd3, 8'h00, 8'h7F);
        expect_frame(8'h7F, 1'b1);
        gap();
        gap();
        // Negative clamp: -381 -> 0x81, never 0x80.
        beat(8'd2, 8'h81, 8'h81);
        beat(8'd2, 8'h00, 8'h81);
        expect_frame(8'h81, 1'b1);
        gap();
        gap();

        // Back-to-back frames. i_len/i_bias on non-first beats must be ignored.
        beat(8'd2, 8'h00, 8'h01);
        beat(8'd9, 8'h55, 8'h02);
        expect_frame(8'h03, 1'b1);
        beat(8'd2, 8'h00, 8'h03);
        beat(8'd7, 8'h7F, 8'h04);
        expect_frame(8'h07, 1'b1);
        gap();
        gap();

        // len=0 behaves as len=1.
        beat(8'd0, 8'h02, 8'h01);
        expect_frame(8'h03, 1'b1);
        gap();
        chk("len0_busy", {31'd0, o_busy}, 32'd0);
        gap();

        // Reset mid-frame discards the frame and clears sticky sat.
        beat(8'd5, 8'h00, 8'h01);
        beat(8'd5, 8'h00, 8'h02);
        @(negedge clk);
        i_psum_v = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        chk("mid_rst_data", {24'd0, o_data}, 32'd0);
        chk("mid_rst_v", {31'd0, o_data_v}, 32'd0);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        chk("mid_rst_sat", {31'd0, o_sat}, 32'd0);
        rst = 1'b0;
        gap();
        beat(8'd2, 8'h00, 8'h05);
        beat(8'd2, 8'h00, 8'h06);
        expect_frame(8'h0B, 1'b0);
        gap();
        gap();

        // Negative result: ReLU zeroes it. Otherwise -32 = 0xE0.
        beat(8'd2, 8'h00, 8'hF0);
        beat(8'd2, 8'h00, 8'hF0);
`ifdef PSUM_RELU_EN
        expect_frame(8'h00, 1'b0);
`else
        expect_frame(8'hE0, 1'b0);
`endif
        repeat (5) gap();
        chk("all_frames_seen", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream consumer of the 8-lane dot-product PE. One 8-bit partial sum (Q-format, symmetric saturated) arrives per valid beat.
- Accumulates a programmable number of partial sums into one output neuron value, so vectors longer than 8 elements can be computed.
- Adds a bias once per frame, saturates to 8 bits, and emits one valid pulse per frame to the activation/writeback stage.

Parameters:
CNT_W, 8, width of beat-count field; max frame length 2^CNT_W-1 beats
ACC_W, 18, internal accumulator width; must be >= 8+CNT_W+1

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
i_len  input  CNT_W  partial sums per frame; sampled on first beat of frame
i_bias  input  8  signed bias; sampled on first beat of frame
i_psum  input  8  signed partial sum from dot PE
i_psum_v  input  1  partial sum valid
o_data  output  8  signed saturated frame result
o_data_v  output  1  one-cycle result valid pulse
o_busy  output  1  high while a frame is in progress (state ACC)
o_sat  output  1  sticky: any output saturation since reset

Behaviour:
- Reset values: o_data=0, o_data_v=0, o_busy=0, o_sat=0; state IDLE; accumulator and counter cleared. Reset mid-frame discards the frame; no o_data_v is produced for it.
- States: IDLE, ACC. No backpressure; every beat with i_psum_v=1 is consumed.
- IDLE, i_psum_v=1 (first beat):
  - latch len = (i_len==0) ? 1 : i_len.
  - acc <= sext(i_bias) + sext(i_psum); cnt <= 1.
  - If len==1: frame completes this beat and state stays IDLE. Otherwise go to ACC.
- ACC, i_psum_v=1: acc <= acc + sext(i_psum); cnt <= cnt+1. If cnt+1==len, the frame completes and state goes to IDLE.
- ACC, i_psum_v=0: hold all state. Gaps of any length are allowed.
- Completion: on the cycle after the last beat, o_data_v=1 and o_data = sat8(final acc). Latency from last beat to o_data_v is exactly 1 cycle.
- sat8 clamps to [-127, +127]. -128 is never produced, matching the PE's symmetric saturation.
- o_data holds its value until the next completion. o_data_v is high for exactly one cycle per frame.
- o_sat is set when a clamp occurs at completion. Only rst clears it.
- Accumulator arithmetic is full precision, ACC_W bits. With ACC_W >= 8+CNT_W+1 it cannot overflow, so no internal wrap occurs.
- Back-to-back frames: the first beat of frame N+1 may arrive on the cycle immediately after frame N's last beat, i.e. the same cycle o_data_v is high for frame N. It is accepted in IDLE with no bubble.
- i_len and i_bias are ignored on every beat except the first beat of a frame.
- o_busy = (state==ACC).

Optional Feature:
- Macro PSUM_RELU_EN.
- Defined: a ReLU is applied after saturation. A negative result is output as 0x00. o_sat still reflects clamping before the ReLU.
- Undefined: a signed saturated value is output unchanged.

Test Plan:
- Reset, then len=1, bias=0x05, psum=0x10 -> one cycle later o_data=0x15, o_data_v=1 for 1 cycle, o_busy never high.
- len=4, bias=0, psums 0x10, 0x20, 0xF0(-16), 0x08 with a 3-cycle gap after beat 2 -> o_busy high from beat 1 until the last beat. o_data=0x28 exactly 1 cycle after beat 4. No o_data_v during the gaps.
- len=3, bias=0x7F, psums 0x7F, 0x7F, 0x7F -> o_data=0x7F, o_sat=1. Then len=2, bias=0x81, psums 0x81, 0x81 -> o_data=0x81 (-127), not 0x80.
- Back-to-back: frame A (len=2, bias=0, 0x01, 0x02) immediately followed by frame B (len=2, bias=0, 0x03, 0x04) with i_psum_v continuously high -> o_data_v pulses 2 cycles apart with 0x03 then 0x07. i_len/i_bias changes on non-first beats have no effect.
- len=0 treated as 1: bias=0x02, psum=0x01 -> o_data=0x03 after 1 cycle. rst asserted after beat 2 of a len=5 frame -> no o_data_v; all outputs return to reset values; the next frame computes from scratch.
- With PSUM_RELU_EN: len=2, bias=0, psums 0xF0, 0xF0 -> o_data=0x00. Without the macro -> o_data=0xE0.
